// File: rtl/pmc_pkg.sv
// Shared types and sizes for the PMC column-serial readout path.
package pmc_pkg;

    localparam int PMC_COLUMNS = 32;
    localparam int PMC_BITS    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        ACTIVE  = 2'd2
    } pmc_state_t;

endpackage

// File: rtl/pmc_rx_shift_array.sv
// PMC_COLUMNS parallel PMC_BITS-deep shift registers, MSB-first, one bit per shift_en.
module pmc_rx_shift_array
    import pmc_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  shift_en,
    input  logic [PMC_COLUMNS-1:0]                pm_dout,
    output logic [PMC_COLUMNS-1:0][PMC_BITS-1:0]  shreg
);

    logic [PMC_COLUMNS-1:0][PMC_BITS-1:0] shreg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (shift_en) begin
            for (int c = 0; c < PMC_COLUMNS; c++) begin
                shreg_q[c] <= {shreg_q[c][PMC_BITS-2:0], pm_dout[c]};
            end
        end
    end

    assign shreg = shreg_q;

endmodule

// File: rtl/pmc_receiver.sv
// PMC readout deserializer: sh/pclk framed capture into a one-deep valid/ready word buffer.
// Optional sticky drop flag enabled by defining PMC_RECEIVER_OVERRUN_EN.
module pmc_receiver
    import pmc_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sh,
    input  logic                                  pclk,
    input  logic [PMC_COLUMNS-1:0]                pm_dout,
    output logic [PMC_COLUMNS-1:0][PMC_BITS-1:0]  data,
    output logic                                  data_valid,
    input  logic                                  data_ready,
    output logic                                  busy,
    output logic                                  overrun,
    input  logic                                  overrun_clr
);

    pmc_state_t                            state_q, state_d;
    logic [3:0]                            bit_cnt_q, bit_cnt_d;
    logic [PMC_COLUMNS-1:0][PMC_BITS-1:0]  data_q, data_d;
    logic                                  data_valid_q, data_valid_d;
    logic                                  busy_q;
    logic                                  capture, complete, drop, handshake;
    logic [PMC_COLUMNS-1:0][PMC_BITS-1:0]  shreg, word;
    logic [PMC_COLUMNS-1:0]                unused_msb;

    pmc_rx_shift_array u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (capture),
        .pm_dout  (pm_dout),
        .shreg    (shreg)
    );

    // The completing bit is taken straight from pm_dout so the word is ready the next cycle.
    always_comb begin
        word       = '0;
        unused_msb = '0;
        for (int c = 0; c < PMC_COLUMNS; c++) begin
            word[c]       = {shreg[c][PMC_BITS-2:0], pm_dout[c]};
            unused_msb[c] = shreg[c][PMC_BITS-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        capture      = 1'b0;
        complete     = 1'b0;
        drop         = 1'b0;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        handshake    = data_valid_q && data_ready;

        case (state_q)
            IDLE: begin
                if (sh) state_d = WAITING;
            end
            WAITING: begin
                if (pclk) begin
                    capture   = 1'b1;
                    state_d   = ACTIVE;
                    bit_cnt_d = 4'd1;
                end else if (!sh) begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                // sh is deliberately ignored: a started word always runs to 16 bits
                if (pclk) begin
                    capture = 1'b1;
                    if (bit_cnt_q == 4'd15) begin
                        complete  = 1'b1;
                        state_d   = WAITING;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (!data_valid_q || handshake) begin
                data_d       = word;
                data_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (handshake) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            busy_q       <= (state_d != IDLE);
        end
    end

`ifdef PMC_RECEIVER_OVERRUN_EN
    logic overrun_q;

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst)              overrun_q <= 1'b0;
        else if (drop)        overrun_q <= 1'b1;
        else if (overrun_clr) overrun_q <= 1'b0;
    end

    assign overrun = overrun_q;
`else
    logic [1:0] unused_ovr;
    assign unused_ovr = {overrun_clr, drop};
    assign overrun    = 1'b0;
`endif

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pmc_receiver.sv
// Directed self-checking bench for pmc_receiver.
module tb_pmc_receiver;
    import pmc_pkg::*;

    logic                                  clk = 1'b0;
    logic                                  rst;
    logic                                  sh;
    logic                                  pclk;
    logic [PMC_COLUMNS-1:0]                pm_dout;
    logic [PMC_COLUMNS-1:0][PMC_BITS-1:0]  data;
    logic                                  data_valid;
    logic                                  data_ready;
    logic                                  busy;
    logic                                  overrun;
    logic                                  overrun_clr;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PMC_RECEIVER_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    pmc_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .sh          (sh),
        .pclk        (pclk),
        .pm_dout     (pm_dout),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PMC_COLUMNS-1:0][PMC_BITS-1:0] rep(input logic [15:0] v);
        logic [PMC_COLUMNS-1:0][PMC_BITS-1:0] w;
        for (int c = 0; c < PMC_COLUMNS; c++) w[c] = v;
        return w;
    endfunction

    // Strobes bits k0..k1 of w (bit 15-k on strobe k), one strobe per cycle.
    task automatic send_range(input logic [PMC_COLUMNS-1:0][PMC_BITS-1:0] w,
                              input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            pclk = 1'b1;
            for (int c = 0; c < PMC_COLUMNS; c++) pm_dout[c] = w[c][15-k];
            tick();
        end
        pclk    = 1'b0;
        pm_dout = '0;
    endtask

    task automatic consume();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    logic [PMC_COLUMNS-1:0][PMC_BITS-1:0] wcol;

    initial begin
        rst = 1'b1; sh = 1'b0; pclk = 1'b0; pm_dout = '0;
        data_ready = 1'b0; overrun_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_data",  data,       '0);
        chk("rst_valid", data_valid, 0);
        chk("rst_busy",  busy,       0);
        chk("rst_ovr",   overrun,    0);

        // single word, 0xA5C3 on every column
        sh = 1'b1;
        tick();
        chk("busy_after_sh", busy, 1);
        send_range(rep(16'hA5C3), 0, 14);
        chk("valid_before_16th", data_valid, 0);
        send_range(rep(16'hA5C3), 15, 15);
        chk("valid_after_16th", data_valid, 1);
        chk("word_a5c3", data, rep(16'hA5C3));
        consume();
        chk("valid_cleared", data_valid, 0);
        chk("data_held", data, rep(16'hA5C3));

        // column independence
        for (int c = 0; c < PMC_COLUMNS; c++) wcol[c] = 16'(c * 16'h0101);
        send_range(wcol, 0, 15);
        chk("colind_data",  data, wcol);
        chk("colind_valid", data_valid, 1);
        chk("busy_waiting", busy, 1);
        consume();

        // overrun: second word dropped while buffer full
        send_range(rep(16'h1234), 0, 15);
        chk("ovr_first", data, rep(16'h1234));
        chk("ovr_none_yet", overrun, 0);
        send_range(rep(16'hFFFF), 0, 15);
        chk("ovr_data_kept", data, rep(16'h1234));
        chk("ovr_valid", data_valid, 1);
        chk("ovr_flag", overrun, OVR_EXP);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // accept and complete in the same cycle
        send_range(rep(16'h5A5A), 0, 14);
        data_ready = 1'b1;
        send_range(rep(16'h5A5A), 15, 15);
        data_ready = 1'b0;
        chk("simul_data",  data, rep(16'h5A5A));
        chk("simul_valid", data_valid, 1);
        chk("simul_ovr",   overrun, 0);
        consume();

        // sh drops mid-word: word still completes
        send_range(rep(16'h3C96), 0, 4);
        sh = 1'b0;
        tick();
        chk("abort_busy", busy, 1);
        send_range(rep(16'h3C96), 5, 15);
        chk("abort_data",  data, rep(16'h3C96));
        chk("abort_valid", data_valid, 1);
        chk("abort_waiting_busy", busy, 1);
        tick();
        chk("waiting_to_idle", busy, 0);
        consume();

        // strobes in IDLE are ignored
        send_range(rep(16'hFFFF), 0, 2);
        chk("idle_pclk_busy",  busy, 0);
        chk("idle_pclk_valid", data_valid, 0);

        // reset mid-word
        sh = 1'b1;
        tick();
        send_range(rep(16'hBEEF), 0, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sh  = 1'b0;
        chk("midrst_data",  data, '0);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_busy",  busy, 0);
        chk("midrst_ovr",   overrun, 0);
        sh = 1'b1;
        tick();
        send_range(rep(16'h0F0F), 0, 15);
        chk("postrst_data",  data, rep(16'h0F0F));
        chk("postrst_valid", data_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
